fetch_ctrl: RTL and testbench

- Fetch-stage controller. Owns the program counter and sequences instruction fetch from instruction memory with a valid/ready request and response handshake.
- Applies branch/jump redirects from execute, holds the fetched instruction until decode accepts it, and discards stale responses after a redirect.
- Sits between the imem port and the IF/ID pipeline register; replaces free-running PC update with a handshake-driven scheduler.

---
 rtl/fetch_ctrl.sv | 104 ++++++++++
 tb/tb_fetch_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues one imem request at a time,
// holds the returned instruction for decode and drops responses made stale by redirects.
module fetch_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_p4,
  output logic [XLEN-1:0] if_instr,
  output logic [31:0]     fetch_count,
  output logic [31:0]     flush_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic            drop;
  logic [XLEN-1:0] tgt;

  assign tgt            = redirect_pc & ~XLEN'(3);
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;
  assign if_pc_p4       = if_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      fetch_count <= '0;
      flush_count <= '0;
    end else if (redirect_valid) begin
      pc       <= tgt;
      if_valid <= 1'b0;
      case (state)
        S_REQ: begin
          // an accepted old-address request must still be drained
          if (imem_req_ready) begin
            state <= S_WAIT;
            drop  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            flush_count <= flush_count + 32'd1;
            drop        <= 1'b0;
            state       <= S_REQ;
          end else begin
            drop <= 1'b1;
          end
        end
        default: state <= S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (drop) begin
              drop        <= 1'b0;
              flush_count <= flush_count + 32'd1;
              state       <= S_REQ;
            end else begin
              if_instr <= imem_rsp_data;
              if_pc    <= pc;
              if_valid <= 1'b1;
              state    <= S_HOLD;
            end
          end
        end
        default: begin
          if (if_ready) begin
            if_valid    <= 1'b0;
            pc          <= pc + XLEN'(4);
            fetch_count <= fetch_count + 32'd1;
            state       <= S_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Random-stimulus bench for fetch_ctrl; the bench plays imem and decode
// and tracks expected fetch addresses, deliveries and flushes transaction-wise.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_pc_p4;
  logic [31:0] if_instr;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_pc_p4(if_pc_p4), .if_instr(if_instr),
    .fetch_count(fetch_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // reference: outstanding request, held instruction, next useful fetch pc
  bit          m_out, m_stale, m_hold;
  int          m_lat;
  logic [31:0] m_addr, m_pc, m_hpc, m_hinstr, m_fetch, m_flush;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_out = 0; m_stale = 0; m_hold = 0; m_lat = 0;
    m_addr = '0; m_pc = RST_PC; m_hpc = '0; m_hinstr = '0;
    m_fetch = '0; m_flush = '0;
  endtask

  task automatic check_all();
    bit want_req;
    want_req = !m_out && !m_hold;
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, want_req});
    if (want_req) chk("req_addr", imem_req_addr, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_hold});
    if (m_hold) begin
      chk("if_pc", if_pc, m_hpc);
      chk("if_instr", if_instr, m_hinstr);
      chk("if_pc_p4", if_pc_p4, m_hpc + 32'd4);
    end
    chk("fetch_count", fetch_count, m_fetch);
    chk("flush_count", flush_count, m_flush);
  endtask

  task automatic step(input int pr, input int pq, input int pi,
                      input int ps);
    logic [31:0] tgt;
    @(negedge clk);
    check_all();
    redirect_valid = ($urandom_range(99) < pr);
    case ($urandom_range(3))
      0: redirect_pc = 32'hFFFF_FFFF - $urandom_range(7);
      1: redirect_pc = $urandom_range(255);
      default: redirect_pc = $urandom;
    endcase
    imem_req_ready = ($urandom_range(99) < pq);
    if_ready = ($urandom_range(99) < pi);
    if (m_out) begin
      imem_rsp_valid = (m_lat == 0);
      imem_rsp_data = mem(m_addr);
    end else begin
      imem_rsp_valid = ($urandom_range(99) < ps);
      imem_rsp_data = $urandom;
    end
    tgt = {redirect_pc[31:2], 2'b00};
    if (m_out) begin
      if (imem_rsp_valid) begin
        m_out = 0;
        if (m_stale || redirect_valid) m_flush++;
        else begin
          m_hold = 1; m_hpc = m_addr; m_hinstr = imem_rsp_data;
        end
      end else m_lat--;
    end else if (m_hold) begin
      if (redirect_valid) m_hold = 0;
      else if (if_ready) begin
        m_hold = 0; m_fetch++; m_pc = m_pc + 32'd4;
      end
    end else if (imem_req_ready) begin
      m_out = 1; m_addr = m_pc; m_stale = 0;
      m_lat = $urandom_range(3);
    end
    if (redirect_valid) begin
      m_pc = tgt;
      if (m_out) m_stale = 1;
    end
  endtask

  // reset lands mid-cycle; a stale response shows up right after release
  task automatic async_reset();
    @(negedge clk);
    check_all();
    #2 rst_n = 1'b0;
    redirect_valid = 0; imem_req_ready = 0; if_ready = 0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    model_reset();
    @(negedge clk);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    check_all();
    rst_n = 1'b1;
    for (int i = 0; i < 400; i++) step(10, 70, 70, 10);
    for (int i = 0; i < 300; i++) step(2, 100, 100, 0);
    for (int i = 0; i < 200; i++) step(5, 50, 15, 20);
    async_reset();
    for (int i = 0; i < 300; i++) step(30, 60, 60, 10);
    async_reset();
    for (int i = 0; i < 200; i++) step(10, 80, 80, 10);
    @(negedge clk);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
